os_16bit_split: RTL and testbench

OS_16BIT_SPLIT -- requirements
Module: os_16bit_split

---
 rtl/os_16bit_split.sv | 137 +++++++++++++
 tb/tb_os_16bit_split.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/os_16bit_split.sv
// Splits 16-bit GF(2) operand pairs into Karatsuba lo/hi/mid 8-bit beats.
// Latency push->first beat 2 cycles; beats hold under out_ready=0, in_ready=0 when FIFO full.
module os_16bit_split #(
    parameter int IN_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  x,
    output logic [7:0]  w,
    output logic [1:0]  tag,
    output logic        last,
    output logic [7:0]  op_cnt
);

    localparam int AW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int CW = $clog2(IN_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, S_LO, S_HI, S_MID} state_t;

    state_t         state_q, state_d;
    logic [31:0]    mem [IN_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           full, empty, push, pop;
    logic [15:0]    ra, rb;
    logic [31:0]    head;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(IN_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full     = (count == CW'(IN_DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    // Full blocks the push even if a pop frees a slot this same cycle.
    assign push     = in_valid && !full;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {a, b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        out_valid = 1'b0;
        x         = '0;
        w         = '0;
        tag       = 2'b00;
        last      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                out_valid = 1'b1;
                x         = ra[7:0];
                w         = rb[7:0];
                tag       = 2'b00;
                if (out_ready) begin
                    state_d = S_HI;
                end
            end
            S_HI: begin
                out_valid = 1'b1;
                x         = ra[15:8];
                w         = rb[15:8];
                tag       = 2'b01;
                if (out_ready) begin
                    state_d = S_MID;
                end
            end
            S_MID: begin
                out_valid = 1'b1;
                x         = ra[7:0] ^ ra[15:8];
                w         = rb[7:0] ^ rb[15:8];
                tag       = 2'b10;
                last      = 1'b1;
                // Chain straight into the next set so sustained rate is one beat per cycle.
                if (out_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = S_LO;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ra      <= '0;
            rb      <= '0;
            op_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                ra <= head[31:16];
                rb <= head[15:0];
            end
            if (state_q == S_MID && out_ready) begin
                op_cnt <= op_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_os_16bit_split.sv
// Bench for os_16bit_split: directed scenarios plus random traffic against a beat-queue model.
module tb_os_16bit_split;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, last;
    logic [15:0] a, b;
    logic [7:0]  x, w, op_cnt;
    logic [1:0]  tag;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] w;
        logic [1:0] tag;
        logic       last;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] exp_cnt = 8'd0;
    int         sets_in = 0;

    always #5 clk = ~clk;

    os_16bit_split #(.IN_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .w(w), .tag(tag), .last(last), .op_cnt(op_cnt)
    );

    task automatic check_val(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input string name, input logic [7:0] ex, input logic [7:0] ew,
                               input logic [1:0] et, input logic el);
        check_val(name, 32'({out_valid, x, w, tag, last}), 32'({1'b1, ex, ew, et, el}));
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic wait_idle;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (!out_valid && exp_q.size() == 0) break;
            tick;
        end
        check_val("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    // Reference model: every accepted pair contributes three expected beats in order.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_cnt = 8'd0;
            sets_in = 0;
            check_val("rst_out_valid", 32'(out_valid), 32'd0);
            check_val("rst_op_cnt", 32'(op_cnt), 32'd0);
        end else begin
            check_val("op_cnt", 32'(op_cnt), 32'(exp_cnt));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_beat", 32'(out_valid), 32'd0);
                end else begin
                    check_val("beat", 32'({x, w, tag, last}), 32'(exp_q[0]));
                    if (out_ready) begin
                        if (exp_q[0].last) exp_cnt = exp_cnt + 8'd1;
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check_val("idle_zero", 32'({x, w, tag, last}), 32'd0);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{x: a[7:0],  w: b[7:0],  tag: 2'd0, last: 1'b0});
                exp_q.push_back('{x: a[15:8], w: b[15:8], tag: 2'd1, last: 1'b0});
                exp_q.push_back('{x: a[7:0] ^ a[15:8], w: b[7:0] ^ b[15:8], tag: 2'd2, last: 1'b1});
                sets_in++;
            end
        end
    end

    initial begin
        int cyc;
        a = '0;
        b = '0;
        do_reset;
        rst = 1'b1;
        #1;
        check_val("reset_out_valid", 32'(out_valid), 32'd0);
        check_val("reset_outputs", 32'({x, w, tag, last}), 32'd0);
        check_val("reset_op_cnt", 32'(op_cnt), 32'd0);
        tick;
        rst = 1'b0;
        tick;
        check_val("reset_in_ready", 32'(in_ready), 32'd1);

        // Basic split and latency
        out_ready = 1'b1;
        a = 16'h1234; b = 16'hABCD; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        check_val("lat_t1_idle", 32'(out_valid), 32'd0);
        tick; expect_beat("basic_lo", 8'h34, 8'hCD, 2'b00, 1'b0);
        tick; expect_beat("basic_hi", 8'h12, 8'hAB, 2'b01, 1'b0);
        tick; expect_beat("basic_mid", 8'h26, 8'h66, 2'b10, 1'b1);
        tick;
        check_val("basic_done_valid", 32'(out_valid), 32'd0);
        check_val("basic_op_cnt", 32'(op_cnt), 32'd1);

        // Back-to-back sets with no bubble
        do_reset;
        out_ready = 1'b1;
        a = 16'h1234; b = 16'hABCD; in_valid = 1'b1;
        tick;
        a = 16'hFF00; b = 16'h00FF;
        tick;
        in_valid = 1'b0;
        expect_beat("b2b_0", 8'h34, 8'hCD, 2'b00, 1'b0); tick;
        expect_beat("b2b_1", 8'h12, 8'hAB, 2'b01, 1'b0); tick;
        expect_beat("b2b_2", 8'h26, 8'h66, 2'b10, 1'b1); tick;
        expect_beat("b2b_3", 8'h00, 8'hFF, 2'b00, 1'b0); tick;
        expect_beat("b2b_4", 8'hFF, 8'h00, 2'b01, 1'b0); tick;
        expect_beat("b2b_5", 8'hFF, 8'hFF, 2'b10, 1'b1); tick;
        check_val("b2b_op_cnt", 32'(op_cnt), 32'd2);

        // Backpressure held in S_HI
        do_reset;
        out_ready = 1'b1;
        a = 16'h1234; b = 16'hABCD; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_beat("bp_hold", 8'h12, 8'hAB, 2'b01, 1'b0);
            tick;
        end
        out_ready = 1'b1;
        expect_beat("bp_release", 8'h12, 8'hAB, 2'b01, 1'b0);
        tick;
        expect_beat("bp_mid", 8'h26, 8'h66, 2'b10, 1'b1);
        tick;

        // Capacity: register plus two FIFO entries
        do_reset;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 16'($urandom); b = 16'($urandom); in_valid = 1'b1;
            check_val("full_in_ready", 32'(in_ready), 32'(i < 3));
            tick;
        end
        in_valid = 1'b0;
        check_val("full_held", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick;
        tick;
        check_val("full_mid_last", 32'(last), 32'd1);
        check_val("full_mid_in_ready", 32'(in_ready), 32'd0);
        tick;
        check_val("full_after_mid", 32'(in_ready), 32'd1);
        wait_idle;

        // Reset in the middle of a set with two queued
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom); in_valid = 1'b1;
            tick;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_val("mid_rst_in_hi", 32'(tag), 32'd1);
        check_val("mid_rst_cnt_pre", 32'(op_cnt), 32'd3);
        rst = 1'b1;
        #1;
        check_val("mid_rst_valid", 32'(out_valid), 32'd0);
        check_val("mid_rst_op_cnt", 32'(op_cnt), 32'd0);
        tick;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            check_val("mid_rst_quiet", 32'(out_valid), 32'd0);
            check_val("mid_rst_in_ready", 32'(in_ready), 32'd1);
        end

        // Random traffic through 256 sets, then op_cnt wrap
        do_reset;
        cyc = 0;
        while (sets_in < 256 && cyc < 20000) begin
            in_valid  = 1'($urandom_range(0, 1));
            a         = 16'($urandom);
            b         = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick;
            cyc++;
        end
        in_valid = 1'b0;
        check_val("wrap_sets", 32'(sets_in), 32'd256);
        wait_idle;
        check_val("wrap_256", 32'(op_cnt), 32'd0);
        a = 16'($urandom); b = 16'($urandom); in_valid = 1'b1;
        tick;
        wait_idle;
        check_val("wrap_257", 32'(op_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
